note_lane_scroller: RTL and testbench

- Parametrised falling-note renderer for the VGA path. It supports N lanes, configurable geometry and per-mode scroll speed.
- Each lane is a shift register: a hidden lead-in buffer followed by the visible rows. Lane columns are rendered as block colour or background.
- Scroll steps are committed only at frame start, so frames never tear. A hit-line status vector goes to the scoring logic.
- The block sits between the note sequencer (`note` source) and the VGA pixel mux, driven by the pixel scan coordinates.

---
 rtl/note_lane_scroller_pkg.sv | 21 ++
 rtl/note_lane_scroller_if.sv | 14 +
 rtl/note_lane_scroller_shift.sv | 43 ++++
 rtl/note_lane_scroller.sv | 128 ++++++++++++
 tb/tb_note_lane_scroller.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/note_lane_scroller_pkg.sv
// note_lane_pkg: shared types and helpers for the falling-note lane renderer.
//   rgb888_t          - 24-bit pixel colour {R,G,B}
//   *_COLOR_DEF       - default colours for blocks, hit line and background
//   lane_left_x()     - x coordinate of the left edge of a lane
package note_lane_pkg;

    typedef logic [23:0] rgb888_t;

    localparam rgb888_t BG_COLOR_DEF    = 24'hFFFFFF;
    localparam rgb888_t BLOCK_COLOR_DEF = 24'h000000;
    localparam rgb888_t HIT_COLOR_DEF   = 24'hFF0000;

    function automatic int unsigned lane_left_x(
        input int unsigned lane_x0,
        input int unsigned lane_pitch,
        input int unsigned idx
    );
        return lane_x0 + idx * lane_pitch;
    endfunction

endpackage

// File: rtl/note_lane_scroller_if.sv
// note_lane_scroller_if: VGA pixel bus between the scan generator and the
// note lane renderer.
//   pos_x, pos_y - current scan coordinates (driven by the master)
//   pos_data     - registered pixel colour (driven by the slave)
interface note_lane_scroller_if;
    import note_lane_pkg::*;

    logic [9:0] pos_x;
    logic [9:0] pos_y;
    rgb888_t    pos_data;

    modport master (output pos_x, output pos_y, input pos_data);
    modport slave  (input pos_x, input pos_y, output pos_data);
endinterface

// File: rtl/note_lane_scroller_shift.sv
// note_lane_shift: one note lane, a (ROWS+BUF_LEN)-bit shift register.
//   vga_clk, rst_n - clock, synchronous active-low reset
//   en             - commit enable: shift din into bit 0
//   din            - serial note input
//   row            - visible row to read (0..ROWS-1)
//   rd_bit         - combinational bit at visible row 'row'
//   hit            - registered bit at visible row HIT_ROW, refreshed on commit
module note_lane_shift #(
    parameter int unsigned ROWS    = 480,
    parameter int unsigned BUF_LEN = 20,
    parameter int unsigned HIT_ROW = 460,
    parameter int unsigned RW      = 9
) (
    input  logic          vga_clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          din,
    input  logic [RW-1:0] row,
    output logic          rd_bit,
    output logic          hit
);
    localparam int unsigned TOT = ROWS + BUF_LEN;

    logic [TOT-1:0]  vec;
    logic [TOT-1:0]  vec_next;
    logic [ROWS-1:0] vis;

    assign vec_next = {vec[TOT-2:0], din};
    assign vis      = vec[TOT-1:BUF_LEN];
    assign rd_bit   = vis[row];

    // The hit tap is loaded from the post-shift vector so it is valid
    // together with step_pulse.
    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            vec <= '0;
            hit <= 1'b0;
        end else if (en) begin
            vec <= vec_next;
            hit <= vec_next[BUF_LEN + HIT_ROW];
        end
    end
endmodule

// File: rtl/note_lane_scroller.sv
// note_lane_scroller: falling-note renderer for the VGA path.
//   vga_clk, rst_n - pixel clock, synchronous active-low reset
//   pix            - pixel bus: pos_x/pos_y in, registered pos_data out
//   note           - per-lane note level, sampled on each committed step
//   frame_start    - one-cycle pulse at frame start; steps commit only here
//   pause          - freezes the divider and drops any pending step
//   speed          - step period = STEP_DIV >> speed
//   lane_at_hit    - per-lane bit at visible row HIT_ROW
//   step_pulse     - one-cycle pulse after each committed step
module note_lane_scroller
    import note_lane_pkg::*;
#(
    parameter int unsigned LANES       = 7,
    parameter int unsigned LANE_X0     = 112,
    parameter int unsigned LANE_PITCH  = 64,
    parameter int unsigned LANE_W      = 32,
    parameter int unsigned ROWS        = 480,
    parameter int unsigned BUF_LEN     = 20,
    parameter int unsigned STEP_DIV    = 100000,
    parameter int unsigned HIT_ROW     = 460,
    parameter rgb888_t     BLOCK_COLOR = BLOCK_COLOR_DEF,
    parameter rgb888_t     HIT_COLOR   = HIT_COLOR_DEF,
    parameter rgb888_t     BG_COLOR    = BG_COLOR_DEF
) (
    input  logic                  vga_clk,
    input  logic                  rst_n,
    note_lane_scroller_if.slave   pix,
    input  logic [LANES-1:0]      note,
    input  logic                  frame_start,
    input  logic                  pause,
    input  logic [1:0]            speed,
    output logic [LANES-1:0]      lane_at_hit,
    output logic                  step_pulse
);
    localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [CW-1:0]    count;
    logic             step_pending;
    logic [31:0]      term;
    logic             terminal;
    logic             commit;

    logic [RW-1:0]    row_idx;
    logic [LANES-1:0] lane_act;
    logic [LANES-1:0] lane_first;
    logic [LANES-1:0] lane_bit;
    logic             in_rows;
    logic             sel_bit;
    rgb888_t          pix_next;

    // ">=" rather than "==" so a speed increase past the current count
    // fires on the next cycle instead of wrapping through the full range.
    assign term     = (32'(STEP_DIV) >> speed) - 32'd1;
    assign terminal = (32'(count) >= term);
    assign commit   = frame_start & step_pending & ~pause;

    // A terminal on the commit cycle re-arms step_pending, so it waits for
    // the next frame_start rather than being swallowed by this commit.
    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            count        <= '0;
            step_pending <= 1'b0;
            step_pulse   <= 1'b0;
        end else begin
            step_pulse <= commit;
            if (pause) begin
                step_pending <= 1'b0;
            end else if (terminal) begin
                count        <= '0;
                step_pending <= 1'b1;
            end else begin
                count <= count + CW'(1);
                if (commit) begin
                    step_pending <= 1'b0;
                end
            end
        end
    end

    assign row_idx = pix.pos_y[RW-1:0];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int unsigned LX = lane_left_x(LANE_X0, LANE_PITCH, i);

        assign lane_act[i] = (32'(pix.pos_x) >= LX) &&
                             (32'(pix.pos_x) < LX + LANE_W);

        note_lane_shift #(
            .ROWS    (ROWS),
            .BUF_LEN (BUF_LEN),
            .HIT_ROW (HIT_ROW),
            .RW      (RW)
        ) u_lane (
            .vga_clk (vga_clk),
            .rst_n   (rst_n),
            .en      (commit),
            .din     (note[i]),
            .row     (row_idx),
            .rd_bit  (lane_bit[i]),
            .hit     (lane_at_hit[i])
        );
    end

    // Isolate the lowest active lane so overlapping columns resolve to it.
    assign lane_first = lane_act & (~lane_act + LANES'(1));
    assign sel_bit    = |(lane_first & lane_bit);
    assign in_rows    = (32'(pix.pos_y) < ROWS);

    always_comb begin
        pix_next = BG_COLOR;
        if (in_rows && (|lane_act)) begin
            if (sel_bit) begin
                pix_next = BLOCK_COLOR;
            end else if (32'(pix.pos_y) == HIT_ROW) begin
                pix_next = HIT_COLOR;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            pix.pos_data <= '0;
        end else begin
            pix.pos_data <= pix_next;
        end
    end
endmodule

// File: tb/tb_note_lane_scroller.sv
// tb_note_lane_scroller: directed self-checking bench for note_lane_scroller
// with small geometry (3 lanes, 16 rows, 2 hidden bits, divider 8).
module tb_note_lane_scroller;
    import note_lane_pkg::*;

    localparam rgb888_t BLK = 24'h000000;
    localparam rgb888_t HIT = 24'hFF0000;
    localparam rgb888_t BG  = 24'hFFFFFF;

    logic       vga_clk = 1'b0;
    logic       rst_n;
    logic [2:0] note;
    logic       frame_start;
    logic       pause;
    logic [1:0] speed;
    logic [2:0] lane_at_hit;
    logic       step_pulse;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses;

    note_lane_scroller_if pif ();

    note_lane_scroller #(
        .LANES      (3),
        .LANE_X0    (10),
        .LANE_PITCH (8),
        .LANE_W     (4),
        .ROWS       (16),
        .BUF_LEN    (2),
        .STEP_DIV   (8),
        .HIT_ROW    (12)
    ) dut (
        .vga_clk     (vga_clk),
        .rst_n       (rst_n),
        .pix         (pif),
        .note        (note),
        .frame_start (frame_start),
        .pause       (pause),
        .speed       (speed),
        .lane_at_hit (lane_at_hit),
        .step_pulse  (step_pulse)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input rgb888_t exp, input string tag);
        pif.pos_x = 10'(x);
        pif.pos_y = 10'(y);
        tick();
        chk(tag, 32'(pif.pos_data), 32'(exp));
    endtask

    // Requires speed=3 and at least one prior unpaused cycle so a step is pending.
    task automatic do_commit(input logic [2:0] v);
        note        = v;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        note        = 3'b000;
        chk("commit_pulse", 32'(step_pulse), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; note = '0; frame_start = 1'b0; pause = 1'b0; speed = 2'd3;
        pif.pos_x = '0; pif.pos_y = '0;
        tick(); tick();
        chk("rst_pos_data", 32'(pif.pos_data), 32'd0);
        chk("rst_lane_at_hit", 32'(lane_at_hit), 32'd0);
        chk("rst_step_pulse", 32'(step_pulse), 32'd0);
        rst_n = 1'b1;
        tick();

        // Scroll path: one note in lane 0 travels down the column.
        do_commit(3'b001);
        tick();
        chk("pulse_one_cycle", 32'(step_pulse), 32'd0);
        do_commit(3'b000);
        do_commit(3'b000);
        pix(10, 0, BLK, "scroll_row0_lane0");
        pix(18, 0, BG,  "scroll_row0_lane1");
        pix(10, 1, BG,  "scroll_row1_lane0");
        for (int k = 4; k <= 14; k++) do_commit(3'b000);
        chk("hit_before_15", 32'(lane_at_hit), 32'd0);
        do_commit(3'b000);
        chk("hit_at_15", 32'(lane_at_hit), 32'd1);
        pix(10, 12, BLK, "scroll_row12_block");
        do_commit(3'b000);
        chk("hit_after_16", 32'(lane_at_hit), 32'd0);
        do_commit(3'b000);
        do_commit(3'b000);
        pix(10, 15, BLK, "scroll_row15_block");
        do_commit(3'b000);
        pix(10, 15, BG,  "scroll_dropped");
        pix(10, 12, HIT, "scroll_hit_bg");

        // Reset mid-run clears lane contents and outputs.
        for (int k = 0; k < 5; k++) do_commit(3'b010);
        pix(18, 0, BLK, "lane1_row0_set");
        pix(18, 2, BLK, "lane1_row2_set");
        pix(18, 3, BG,  "lane1_row3_clear");
        pif.pos_x = 10'd18; pif.pos_y = 10'd0;
        do_reset();
        chk("midrst_pos_data", 32'(pif.pos_data), 32'd0);
        chk("midrst_lane_at_hit", 32'(lane_at_hit), 32'd0);
        chk("midrst_step_pulse", 32'(step_pulse), 32'd0);
        chk("midrst_count", 32'(dut.count), 32'd0);
        chk("midrst_pending", 32'(dut.step_pending), 32'd0);
        pix(18, 0, BG,  "midrst_row0_bg");
        pix(18, 12, HIT, "midrst_hit_row");
        pix(19, 2, BG,  "midrst_row2_bg");

        // Frame sync: two terminals collapse into one step.
        speed = 2'd0;
        do_reset();
        note = 3'b100;
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            pulses += int'(step_pulse);
        end
        chk("fsync_pending", 32'(dut.step_pending), 32'd1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        note = 3'b000;
        pulses += int'(step_pulse);
        chk("fsync_pending_clr", 32'(dut.step_pending), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            pulses += int'(step_pulse);
        end
        chk("fsync_one_pulse", 32'(pulses), 32'd1);
        // Count is 4; three more cycles reach 7, the next edge is a terminal.
        tick(); tick(); tick();
        chk("fsync_count7", 32'(dut.count), 32'd7);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("coincide_no_pulse", 32'(step_pulse), 32'd0);
        chk("coincide_pending", 32'(dut.step_pending), 32'd1);
        tick();
        chk("coincide_still_none", 32'(step_pulse), 32'd0);
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("coincide_next_fs", 32'(step_pulse), 32'd1);
        speed = 2'd3;
        tick();
        do_commit(3'b000);
        pix(26, 0, BLK, "fsync_single_shift");
        pix(26, 1, BG,  "fsync_no_double");

        // Speed: speed=2 gives a period of 2 cycles.
        speed = 2'd2;
        do_reset();
        tick();
        chk("spd2_c1", 32'(dut.count), 32'd1);
        chk("spd2_p1", 32'(dut.step_pending), 32'd0);
        tick();
        chk("spd2_c2", 32'(dut.count), 32'd0);
        chk("spd2_p2", 32'(dut.step_pending), 32'd1);
        tick();
        chk("spd2_c3", 32'(dut.count), 32'd1);
        tick();
        chk("spd2_c4", 32'(dut.count), 32'd0);
        speed = 2'd0;
        do_reset();
        for (int k = 0; k < 5; k++) tick();
        chk("spd_sw_count5", 32'(dut.count), 32'd5);
        speed = 2'd3;
        tick();
        chk("spd_sw_count0", 32'(dut.count), 32'd0);
        chk("spd_sw_pending", 32'(dut.step_pending), 32'd1);

        // Pause freezes the divider and blocks commits.
        speed = 2'd0;
        do_reset();
        for (int k = 0; k < 10; k++) tick();
        chk("pause_pre_count", 32'(dut.count), 32'd2);
        chk("pause_pre_pending", 32'(dut.step_pending), 32'd1);
        pause = 1'b1;
        tick();
        chk("pause_count_held", 32'(dut.count), 32'd2);
        chk("pause_pending_clr", 32'(dut.step_pending), 32'd0);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            frame_start = 1'b1;
            tick();
            pulses += int'(step_pulse);
            frame_start = 1'b0;
            tick();
            pulses += int'(step_pulse);
        end
        chk("pause_no_pulse", 32'(pulses), 32'd0);
        chk("pause_count_frozen", 32'(dut.count), 32'd2);
        pause = 1'b0;
        tick();
        chk("pause_resume", 32'(dut.count), 32'd3);

        // Geometry, colours and one-cycle pixel latency.
        pix(13, 12, HIT, "geo_13_12");
        pix(14, 12, BG,  "geo_14_12");
        pix(10, 16, BG,  "geo_10_16");
        pix(9, 12,  BG,  "geo_9_12");
        pix(21, 12, HIT, "geo_21_12");
        pix(29, 12, HIT, "geo_29_12");
        pix(30, 12, BG,  "geo_30_12");
        pif.pos_x = 10'd13; pif.pos_y = 10'd12;
        tick();
        chk("lag_first", 32'(pif.pos_data), 32'(HIT));
        pif.pos_x = 10'd14;
        #1;
        chk("lag_hold", 32'(pif.pos_data), 32'(HIT));
        tick();
        chk("lag_update", 32'(pif.pos_data), 32'(BG));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
